// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with clock filter, frame checking, prefix decode and per-key held state.
// Optional: define PS2_TYPEMATIC_FILTER_EN to drop makes of tracked keys that are already held.
module ps2_key_tracker #(
  parameter int unsigned               FILTER_LEN     = 8,
  parameter int unsigned               NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0]     KEY_CODES      = {8'h1D, 8'h1C, 8'h1B, 8'h23},
  parameter int unsigned               TIMEOUT_CYCLES = 50000
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                scan_valid,
  output logic [7:0]          scan_code,
  output logic                scan_break,
  output logic                scan_ext,
  output logic                frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_clk_s1, r_clk_s2;
  logic                  r_dat_s1, r_dat_s2;
  logic                  r_filt, r_filt_d;
  logic [FW-1:0]         r_fcnt;
  logic [TW-1:0]         r_tocnt;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_par;
  logic                  r_ext_pend, r_brk_pend;
  logic [NUM_KEYS-1:0]   r_key_down;
  logic                  r_scan_valid;
  logic [7:0]            r_scan_code;
  logic                  r_scan_break;
  logic                  r_scan_ext;
  logic                  r_frame_err;
  logic                  w_sample;
  logic                  w_timeout;
  logic                  w_good;
  logic                  w_suppress;
  logic [NUM_KEYS-1:0]   w_match;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Counter runs while the synchronised clock disagrees with the filtered one.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FCNT_MAX) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_sample  = r_filt_d & ~r_filt;
  assign w_timeout = (r_state != ST_IDLE) && !w_sample && (r_tocnt == TO_MAX);
  assign w_good    = r_dat_s2 & (^{r_shift, r_par});

  always_ff @(posedge sysclk) begin
    if (reset || (r_state == ST_IDLE) || w_sample) r_tocnt <= '0;
    else                                          r_tocnt <= r_tocnt + 1'b1;
  end

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      w_match[i] = (KEY_CODES[8*i +: 8] == r_shift);
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign w_suppress = !r_brk_pend && !r_ext_pend && (|w_match) &&
                      ((w_match & r_key_down) == w_match);
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (w_sample) begin
      case (r_state)
        ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_key_down   <= '0;
      r_scan_valid <= 1'b0;
      r_scan_code  <= '0;
      r_scan_break <= 1'b0;
      r_scan_ext   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_timeout) begin
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_brk_pend  <= 1'b0;
      end else if (w_sample) begin
        case (r_state)
          ST_IDLE: r_bitcnt <= '0;
          ST_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
          ST_PARITY: r_par <= r_dat_s2;
          ST_STOP: begin
            if (!w_good) begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_brk_pend  <= 1'b0;
            end else if (r_shift == 8'hE0) begin
              r_ext_pend <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_brk_pend <= 1'b1;
            end else begin
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
              if (!w_suppress) begin
                r_scan_valid <= 1'b1;
                r_scan_code  <= r_shift;
                r_scan_break <= r_brk_pend;
                r_scan_ext   <= r_ext_pend;
                if (!r_ext_pend) begin
                  if (r_brk_pend) r_key_down <= r_key_down & ~w_match;
                  else            r_key_down <= r_key_down | w_match;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign key_down   = r_key_down;
  assign scan_valid = r_scan_valid;
  assign scan_code  = r_scan_code;
  assign scan_break = r_scan_break;
  assign scan_ext   = r_scan_ext;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: make/break, extended, frame errors, timeout, glitches, repeats, reset.
module tb_ps2_key_tracker;

  localparam int unsigned TO_CYC = 600;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_down;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       scan_break;
  logic       scan_ext;
  logic       frame_err;

  int n_vec;
  int n_err;
  int n_valid;
  int n_ferr;

  ps2_key_tracker #(
    .FILTER_LEN     (8),
    .NUM_KEYS       (4),
    .KEY_CODES      ({8'h1D, 8'h1C, 8'h1B, 8'h23}),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .sysclk     (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_down   (key_down),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .scan_break (scan_break),
    .scan_ext   (scan_ext),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every high cycle of the pulse outputs, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (scan_valid) n_valid++;
    if (frame_err)  n_ferr++;
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_inv, input logic stop_b,
                            input int unsigned nbits);
    logic [10:0] f;
    f = {stop_b, (~^b) ^ par_inv, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic test_reset;
    logic [15:0] obs;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    obs = {key_down, scan_valid, scan_code, scan_break, scan_ext, frame_err};
    n_vec++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 16'h0);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_make_break;
    int v0;
    logic [13:0] obs;
    v0 = n_valid;
    send_good(8'h1D);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1D, 1'b0, 1'b0, 4'b1000}) begin
      n_err++;
      $display("FAIL make_1D: got %h expected %h", obs, {8'h1D, 1'b0, 1'b0, 4'b1000});
    end
    send_good(8'h23);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h23, 1'b0, 1'b0, 4'b1001}) begin
      n_err++;
      $display("FAIL make_23: got %h expected %h", obs, {8'h23, 1'b0, 1'b0, 4'b1001});
    end
    send_good(8'hF0);
    send_good(8'h1D);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1D, 1'b1, 1'b0, 4'b0001}) begin
      n_err++;
      $display("FAIL break_1D: got %h expected %h", obs, {8'h1D, 1'b1, 1'b0, 4'b0001});
    end
    n_vec++;
    if (n_valid - v0 !== 3) begin
      n_err++;
      $display("FAIL make_break_pulses: got %0d expected 3", n_valid - v0);
    end
  endtask

  task automatic test_extended;
    int v0;
    logic [13:0] obs;
    v0 = n_valid;
    send_good(8'hE0);
    send_good(8'h1D);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1D, 1'b0, 1'b1, 4'b0001}) begin
      n_err++;
      $display("FAIL ext_make_1D: got %h expected %h", obs, {8'h1D, 1'b0, 1'b1, 4'b0001});
    end
    send_good(8'h1C);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1C, 1'b0, 1'b0, 4'b0101}) begin
      n_err++;
      $display("FAIL make_1C_after_ext: got %h expected %h", obs, {8'h1C, 1'b0, 1'b0, 4'b0101});
    end
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h1C);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1C, 1'b1, 1'b1, 4'b0101}) begin
      n_err++;
      $display("FAIL ext_break_1C: got %h expected %h", obs, {8'h1C, 1'b1, 1'b1, 4'b0101});
    end
    n_vec++;
    if (n_valid - v0 !== 3) begin
      n_err++;
      $display("FAIL ext_pulses: got %0d expected 3", n_valid - v0);
    end
  endtask

  task automatic test_frame_err;
    int v0;
    int e0;
    logic [13:0] obs;
    v0 = n_valid;
    e0 = n_ferr;
    send_frame(8'h1B, 1'b1, 1'b1, 11);
    send_frame(8'h1B, 1'b0, 1'b0, 11);
    n_vec++;
    if ({n_valid - v0, n_ferr - e0} !== {32'd0, 32'd2}) begin
      n_err++;
      $display("FAIL bad_parity_stop: got valid=%0d err=%0d expected valid=0 err=2",
               n_valid - v0, n_ferr - e0);
    end
    n_vec++;
    if (key_down !== 4'b0101) begin
      n_err++;
      $display("FAIL key_after_err: got %b expected %b", key_down, 4'b0101);
    end
    send_good(8'h1B);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1B, 1'b0, 1'b0, 4'b0111}) begin
      n_err++;
      $display("FAIL make_1B_after_err: got %h expected %h", obs, {8'h1B, 1'b0, 1'b0, 4'b0111});
    end
    // A bad frame between F0 and the code must cancel the pending break.
    send_good(8'hF0);
    send_frame(8'h2A, 1'b1, 1'b1, 11);
    send_good(8'h1D);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h1D, 1'b0, 1'b0, 4'b1111}) begin
      n_err++;
      $display("FAIL err_clears_break: got %h expected %h", obs, {8'h1D, 1'b0, 1'b0, 4'b1111});
    end
    n_vec++;
    if ({n_valid - v0, n_ferr - e0} !== {32'd2, 32'd3}) begin
      n_err++;
      $display("FAIL frame_err_counts: got valid=%0d err=%0d expected valid=2 err=3",
               n_valid - v0, n_ferr - e0);
    end
  endtask

  task automatic test_timeout;
    int v0;
    int e0;
    logic [13:0] obs;
    send_good(8'hF0);
    send_good(8'h23);
    n_vec++;
    if (key_down !== 4'b1110) begin
      n_err++;
      $display("FAIL break_23: got %b expected %b", key_down, 4'b1110);
    end
    v0 = n_valid;
    e0 = n_ferr;
    send_good(8'hF0);
    send_frame(8'h23, 1'b0, 1'b1, 5);
    repeat (TO_CYC + 100) @(negedge clk);
    n_vec++;
    if ({n_valid - v0, n_ferr - e0} !== {32'd0, 32'd1}) begin
      n_err++;
      $display("FAIL timeout_err: got valid=%0d err=%0d expected valid=0 err=1",
               n_valid - v0, n_ferr - e0);
    end
    send_good(8'h23);
    obs = {scan_code, scan_break, scan_ext, key_down};
    n_vec++;
    if (obs !== {8'h23, 1'b0, 1'b0, 4'b1111}) begin
      n_err++;
      $display("FAIL make_23_after_timeout: got %h expected %h", obs, {8'h23, 1'b0, 1'b0, 4'b1111});
    end
  endtask

  task automatic test_glitch;
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_ferr;
    ps2_data = 1'b0;
    for (int unsigned g = 0; g < 3; g++) begin
      repeat (30) @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (30) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (7) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    send_good(8'hF0);
    send_good(8'h1C);
    n_vec++;
    if ({n_valid - v0, n_ferr - e0} !== {32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL glitch_counts: got valid=%0d err=%0d expected valid=1 err=0",
               n_valid - v0, n_ferr - e0);
    end
    n_vec++;
    if ({scan_code, scan_break, key_down} !== {8'h1C, 1'b1, 4'b1011}) begin
      n_err++;
      $display("FAIL glitch_break_1C: got %h expected %h",
               {scan_code, scan_break, key_down}, {8'h1C, 1'b1, 4'b1011});
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    int exp_rep;
    send_good(8'hF0);
    send_good(8'h1D);
    v0 = n_valid;
    send_good(8'h1D);
    send_good(8'h1D);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_rep = 1;
`else
    exp_rep = 2;
`endif
    n_vec++;
    if (n_valid - v0 !== exp_rep) begin
      n_err++;
      $display("FAIL repeat_make_pulses: got %0d expected %0d", n_valid - v0, exp_rep);
    end
    n_vec++;
    if ({scan_code, scan_break, key_down} !== {8'h1D, 1'b0, 4'b1011}) begin
      n_err++;
      $display("FAIL repeat_make_state: got %h expected %h",
               {scan_code, scan_break, key_down}, {8'h1D, 1'b0, 4'b1011});
    end
    v0 = n_valid;
    send_good(8'h2A);
    send_good(8'h2A);
    n_vec++;
    if ({n_valid - v0, 24'd0, scan_code, key_down} !== {32'd2, 24'd0, 8'h2A, 4'b1011}) begin
      n_err++;
      $display("FAIL untracked_repeat: got pulses=%0d code=%h key=%b expected pulses=2 code=2a key=1011",
               n_valid - v0, scan_code, key_down);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    int e0;
    logic [15:0] obs;
    logic [10:0] f;
    v0 = n_valid;
    e0 = n_ferr;
    f = {1'b1, ~^8'h1B, 8'h1B, 1'b0};
    for (int unsigned i = 0; i < 6; i++) ps2_bit(f[i]);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    obs = {key_down, scan_valid, scan_code, scan_break, scan_ext, frame_err};
    reset = 1'b0;
    n_vec++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_frame: got %h expected %h", obs, 16'h0);
    end
    ps2_data = 1'b1;
    repeat (TO_CYC + 100) @(negedge clk);
    n_vec++;
    if ({n_valid - v0, n_ferr - e0} !== {32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_no_pulse: got valid=%0d err=%0d expected valid=0 err=0",
               n_valid - v0, n_ferr - e0);
    end
    send_good(8'h1C);
    n_vec++;
    if ({scan_code, scan_break, scan_ext, key_down} !== {8'h1C, 1'b0, 1'b0, 4'b0100}) begin
      n_err++;
      $display("FAIL make_after_reset: got %h expected %h",
               {scan_code, scan_break, scan_ext, key_down}, {8'h1C, 1'b0, 1'b0, 4'b0100});
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_valid  = 0;
    n_ferr   = 0;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    test_reset();
    test_make_break();
    test_extended();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
